// File: rtl/coo_operand_loader_pkg.sv
// Shared types for the COO operand loader and the sparse multiplier.
// Holds the FP8 encoding, the default table geometry and the loader FSM states.
package coo_operand_loader_pkg;

  localparam int DEF_MAX_NNZ = 8;
  localparam int DEF_IDX_W   = 3;

  typedef logic [7:0]           fp8_t;
  typedef logic [DEF_IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_CLEAR
  } state_t;

  // Either signed zero counts as zero; sign bit is ignored.
  function automatic logic fp8_is_zero(input fp8_t v);
    return v[6:0] == 7'd0;
  endfunction

endpackage

// File: rtl/coo_operand_loader_if.sv
// COO entry stream: one coordinate/value per accepted valid/ready beat.
interface coo_operand_loader_if
  import coo_operand_loader_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
);

  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  fp8_t             in_data;
  logic [IDX_W-1:0] in_row;
  logic [IDX_W-1:0] in_col;
  logic             in_last;

  modport master (
    output in_valid, in_sel, in_data, in_row, in_col, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sel, in_data, in_row, in_col, in_last,
    output in_ready
  );

endinterface

// File: rtl/coo_slot_table.sv
// One operand table: slots 0..nnz-1 are always the occupied ones, so insert goes
// to slot nnz and delete refills the hole from slot nnz-1.
module coo_slot_table
  import coo_operand_loader_pkg::*;
#(
  parameter int MAX_NNZ = DEF_MAX_NNZ,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              wr_en,
  input  fp8_t                              wr_data,
  input  logic [IDX_W-1:0]                  wr_row,
  input  logic [IDX_W-1:0]                  wr_col,
  output fp8_t [MAX_NNZ-1:0]                data,
  output logic [MAX_NNZ-1:0][IDX_W-1:0]     row,
  output logic [MAX_NNZ-1:0][IDX_W-1:0]     col,
  output logic [MAX_NNZ-1:0]                valid,
  output logic [$clog2(MAX_NNZ+1)-1:0]      nnz,
  output logic                              drop
);

  localparam int NNZ_W = $clog2(MAX_NNZ+1);

  fp8_t [MAX_NNZ-1:0]            data_reg;
  logic [MAX_NNZ-1:0][IDX_W-1:0] row_reg;
  logic [MAX_NNZ-1:0][IDX_W-1:0] col_reg;
  logic [MAX_NNZ-1:0]            valid_reg;
  logic [NNZ_W-1:0]              nnz_reg;

  logic [MAX_NNZ-1:0] hit;
  logic [MAX_NNZ-1:0] is_last;
  logic [MAX_NNZ-1:0] is_free;
  logic               any_hit;
  logic               zero;
  logic               full;
  fp8_t               last_data;
  logic [IDX_W-1:0]   last_row;
  logic [IDX_W-1:0]   last_col;

  generate
    for (genvar gi = 0; gi < MAX_NNZ; gi++) begin : g_slot
      assign hit[gi]     = valid_reg[gi] && (row_reg[gi] == wr_row) && (col_reg[gi] == wr_col);
      assign is_last[gi] = (nnz_reg == NNZ_W'(gi + 1));
      assign is_free[gi] = (nnz_reg == NNZ_W'(gi));
    end
  endgenerate

  assign any_hit = |hit;
  assign zero    = fp8_is_zero(wr_data);
  assign full    = (nnz_reg == NNZ_W'(MAX_NNZ));
  assign drop    = wr_en && !any_hit && !zero && full;

  always_comb begin
    last_data = data_reg[0];
    last_row  = row_reg[0];
    last_col  = col_reg[0];
    for (int i = 0; i < MAX_NNZ; i++) begin
      if (is_last[i]) begin
        last_data = data_reg[i];
        last_row  = row_reg[i];
        last_col  = col_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_reg <= '0;
      nnz_reg   <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < MAX_NNZ; i++) begin
        if (hit[i] && !zero) begin
          data_reg[i] <= wr_data;
        end else if (hit[i] && zero) begin
          data_reg[i] <= last_data;
          row_reg[i]  <= last_row;
          col_reg[i]  <= last_col;
        end else if (!any_hit && !zero && is_free[i]) begin
          data_reg[i]  <= wr_data;
          row_reg[i]   <= wr_row;
          col_reg[i]   <= wr_col;
          valid_reg[i] <= 1'b1;
        end
        // Vacated top slot; also covers deleting the top slot itself.
        if (any_hit && zero && is_last[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
      if (any_hit && zero) begin
        nnz_reg <= nnz_reg - NNZ_W'(1);
      end else if (!any_hit && !zero && !full) begin
        nnz_reg <= nnz_reg + NNZ_W'(1);
      end
    end
  end

  assign data  = data_reg;
  assign row   = row_reg;
  assign col   = col_reg;
  assign valid = valid_reg;
  assign nnz   = nnz_reg;

endmodule

// File: rtl/coo_operand_loader.sv
// Collects a batch of COO entries into the A and B tables, hands them to the
// multiplier with mm_start, then waits for mm_done and clears for the next batch.
module coo_operand_loader
  import coo_operand_loader_pkg::*;
#(
  parameter int MAX_NNZ = DEF_MAX_NNZ,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  coo_operand_loader_if.slave           in_if,
  output fp8_t [MAX_NNZ-1:0]            a_data,
  output logic [MAX_NNZ-1:0][IDX_W-1:0] a_row,
  output logic [MAX_NNZ-1:0][IDX_W-1:0] a_col,
  output logic [MAX_NNZ-1:0]            a_valid,
  output logic [$clog2(MAX_NNZ+1)-1:0]  a_nnz,
  output fp8_t [MAX_NNZ-1:0]            b_data,
  output logic [MAX_NNZ-1:0][IDX_W-1:0] b_row,
  output logic [MAX_NNZ-1:0][IDX_W-1:0] b_col,
  output logic [MAX_NNZ-1:0]            b_valid,
  output logic [$clog2(MAX_NNZ+1)-1:0]  b_nnz,
  output logic                          mm_start,
  input  logic                          mm_done,
  output logic                          ovf
);

  state_t state_reg;
  logic   in_ready_reg;
  logic   mm_start_reg;
  logic   ovf_reg;
  logic   accept;
  logic   clr;
  logic   a_drop;
  logic   b_drop;

  assign accept         = in_if.in_valid && in_ready_reg;
  assign clr            = (state_reg == ST_CLEAR);
  assign in_if.in_ready = in_ready_reg;
  assign mm_start       = mm_start_reg;
  assign ovf            = ovf_reg;

  coo_slot_table #(.MAX_NNZ(MAX_NNZ), .IDX_W(IDX_W)) u_table_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (accept && !in_if.in_sel),
    .wr_data (in_if.in_data),
    .wr_row  (in_if.in_row),
    .wr_col  (in_if.in_col),
    .data    (a_data),
    .row     (a_row),
    .col     (a_col),
    .valid   (a_valid),
    .nnz     (a_nnz),
    .drop    (a_drop)
  );

  coo_slot_table #(.MAX_NNZ(MAX_NNZ), .IDX_W(IDX_W)) u_table_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (accept && in_if.in_sel),
    .wr_data (in_if.in_data),
    .wr_row  (in_if.in_row),
    .wr_col  (in_if.in_col),
    .data    (b_data),
    .row     (b_row),
    .col     (b_col),
    .valid   (b_valid),
    .nnz     (b_nnz),
    .drop    (b_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FILL;
      in_ready_reg <= 1'b1;
      mm_start_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            if (a_drop || b_drop) ovf_reg <= 1'b1;
            if (in_if.in_last) begin
              state_reg    <= ST_ISSUE;
              in_ready_reg <= 1'b0;
              mm_start_reg <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          mm_start_reg <= 1'b0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mm_done) state_reg <= ST_CLEAR;
        end
        ST_CLEAR: begin
          ovf_reg      <= 1'b0;
          in_ready_reg <= 1'b1;
          state_reg    <= ST_FILL;
        end
        default: begin
          state_reg    <= ST_FILL;
          in_ready_reg <= 1'b1;
          mm_start_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/coo_operand_loader.md
COO_OPERAND_LOADER -- requirements
Module: coo_operand_loader

Interface
REQ-001 SHALL have parameter MAX_NNZ, default 8, meaning entry slots per operand matrix.
REQ-002 SHALL have parameter IDX_W, default 3, meaning row/column index width (8x8 matrices).
REQ-003 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  COO entry offered.
REQ-006 SHALL have port in_ready  output  1  loader accepts entry this cycle.
REQ-007 SHALL have port in_sel  input  1  target matrix (0 = A, 1 = B).
REQ-008 SHALL have port in_data  input  8  FP8 value (1 sign, 4 exponent, 3 mantissa bits).
REQ-009 SHALL have port in_row and in_col  input  IDX_W each  entry coordinates.
REQ-010 SHALL have port in_last  input  1  final entry of batch.
REQ-011 SHALL have ports a_data/b_data  output  MAX_NNZ x 8, a_row/a_col/b_row/b_col  output  MAX_NNZ x IDX_W, a_valid/b_valid  output  MAX_NNZ  slot tables.
REQ-012 SHALL have ports a_nnz/b_nnz  output  $clog2(MAX_NNZ+1)  occupied slot count.
REQ-013 SHALL have port mm_start  output  1  one-cycle pulse: tables ready for multiplier.
REQ-014 SHALL have port mm_done  input  1  multiplier finished consuming tables.
REQ-015 SHALL have port ovf  output  1  sticky: entry dropped for lack of slots in current batch.

Function
REQ-016 SHALL implement states FILL, ISSUE, WAIT, CLEAR; in_ready = 1 only in FILL.
REQ-017 Handshake: entry accepted when in_valid && in_ready; in_valid/fields may change only after acceptance.
REQ-018 Accepted entry SHALL appear in the tables on the following cycle (latency 1).
REQ-019 Matching coordinate already valid in selected table: SHALL overwrite that slot's data; nnz unchanged.
REQ-020 New coordinate: SHALL write lowest-index free slot (slot = current nnz), set valid, nnz += 1.
REQ-021 Zero value (in_data[6:0] == 0): SHALL not allocate; if coordinate exists, SHALL clear that slot's valid and compact by moving the highest occupied slot into it, nnz -= 1.
REQ-022 New coordinate with nnz == MAX_NNZ: SHALL drop entry, set ovf; overwrite of existing coordinate still permitted.
REQ-023 Accepting in_last (entry itself processed per REQ-019..022) SHALL move FILL -> ISSUE.
REQ-024 ISSUE SHALL assert mm_start for exactly one cycle, then move to WAIT.
REQ-025 WAIT SHALL hold all tables stable until mm_done = 1, then move to CLEAR; mm_done outside WAIT SHALL be ignored.
REQ-026 CLEAR SHALL zero all valid bits, nnz, and ovf in one cycle, then return to FILL.
REQ-027 Empty batch (in_last on a zero-value entry with no prior entries) SHALL still produce mm_start with nnz = 0.
REQ-028 Data/row/col of invalid slots are don't-care; consumers SHALL rely on valid bits only.

Reset
REQ-029 rst SHALL force state FILL, in_ready = 1 after reset, all valid bits 0, a_nnz = b_nnz = 0, mm_start = 0, ovf = 0.
REQ-030 rst mid-batch or in WAIT SHALL discard all stored entries; no mm_start SHALL be emitted for the aborted batch.
REQ-031 rst SHALL take priority over any simultaneous acceptance or mm_done.

Structure
REQ-032 A shared package SHALL hold the FP8 type, index type, state enum, and MAX_NNZ/IDX_W defaults used by both loader and multiplier.
REQ-033 One sub-module coo_slot_table SHALL implement one operand table (match search, insert, delete-compact); instantiated twice (A, B).

Verification
REQ-034 Load A (0,1)=0x38, B (1,2)=0x40 with in_last -> next cycle tables valid, a_nnz = b_nnz = 1, one mm_start pulse, in_ready = 0.
REQ-035 A (3,3)=0x38 then A (3,3)=0x48 -> a_nnz = 1, slot0 data = 0x48.
REQ-036 A 9 distinct coordinates -> a_nnz = 8, ovf = 1, 9th entry absent; after mm_done then CLEAR, ovf = 0.
REQ-037 A (0,0),(1,1),(2,2) then A (0,0)=0x00 -> a_nnz = 2, slot0 holds (2,2), slot2 invalid.
REQ-038 In WAIT, hold mm_done = 0 for 20 cycles with in_valid = 1 -> no acceptance, tables unchanged; mm_done = 1 -> CLEAR then in_ready = 1 two cycles later.
REQ-039 rst asserted after 3 accepted entries -> next cycle all valid = 0, nnz = 0, no mm_start.
